synapse_weight_loader: RTL
==========================

// Module: synapse_weight_loader
// PURPOSE
//  Upstream feeder for the synaptic weight memory. Accepts a valid/ready stream of
//  (synapse index, 16-bit weight) pairs, buffers them in a small FIFO, and issues one
//  AXI4-Lite write per entry to the weight memory slave. Tracks responses and errors
//  and reports completion at end-of-load (in_last).
// PARAMETERS
//  NUM_SYNAPSES    72401  valid index range 0..NUM_SYNAPSES-1; larger indices are dropped
//  BASE_ADDR       32'h0  byte address of weight 0; entry address = BASE_ADDR + (index<<2)
//  FIFO_DEPTH      8      input FIFO entries, power of 2, >=2
//  TIMEOUT_CYCLES  1024   cycles without a handshake before sticky timeout flag sets
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  in_valid       in   1   input entry valid
//  in_ready       out  1   FIFO can accept (= !full && !rst)
//  in_index       in   32  synapse index
//  in_weight      in   16  synaptic weight
//  in_last        in   1   final entry of a load
//  m_axi_awaddr   out  32  write address
//  m_axi_awvalid  out  1   write address valid
//  m_axi_awready  in   1   write address ready
//  m_axi_wdata    out  32  {16'b0, weight}
//  m_axi_wstrb    out  4   constant 4'b0011
//  m_axi_wvalid   out  1   write data valid
//  m_axi_wready   in   1   write data ready
//  m_axi_bresp    in   2   write response
//  m_axi_bvalid   in   1   write response valid
//  m_axi_bready   out  1   write response ready
//  clr_stats      in   1   clear wr_count, err_count, timeout
//  busy           out  1   state!=IDLE or FIFO non-empty
//  done           out  1   1-cycle pulse when the in_last entry completes
//  wr_count       out  32  writes completed with OKAY
//  err_count      out  16  non-OKAY responses + dropped indices, saturating at 16'hFFFF
//  timeout        out  1   sticky: handshake stalled > TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset: all outputs 0, FIFO emptied, state IDLE; in_ready 0 while rst high.
//  FIFO: push on in_valid&&in_ready; when full, in_ready=0 even if a pop occurs that cycle.
//  FSM (one outstanding transaction, matching the single-transaction slave):
//   IDLE: FIFO non-empty -> pop head, register addr/data/last. If index>=NUM_SYNAPSES:
//     err_count++, done if last, stay IDLE (no AXI traffic); else -> ADDR_DATA.
//   ADDR_DATA: awvalid and wvalid rise together the cycle after the pop. Each drops the
//     cycle after its own handshake (aw_done/w_done flags). Address/data stable while valid.
//     When both are done -> RESP.
//   RESP: bready=1; on bvalid: OKAY -> wr_count++, else err_count++; done if last; -> IDLE.
//  Latency: push at cycle N -> pop at N+1 -> awvalid/wvalid at N+2.
//  Timeout counter resets on any AW/W/B handshake and on state change. Reaching
//   TIMEOUT_CYCLES in ADDR_DATA or RESP sets timeout. FSM keeps waiting (no AXI abort).
//  clr_stats has priority over a same-cycle increment (result 0). It does not affect the FIFO/FSM.
//  Counters: wr_count wraps at 2^32. err_count saturates.
//  rst mid-transaction: valids/bready drop next cycle and the FIFO is flushed. The slave
//   shares rst.
// TESTING
//  1 push idx 5 w 16'hABCD last=1 -> single AW at 0x14, wdata 0x0000ABCD, done pulse, wr_count=1
//  2 push 20 entries back-to-back, slave awready delayed 3 cycles -> in_ready low at 8 held,
//    all 20 written in order, wr_count=20, no loss
//  3 push idx 72401 last=1 -> no AW issued, err_count=1, done pulse, wr_count unchanged
//  4 slave returns bresp=2'b10 once -> err_count=1, loader continues with next entry
//  5 slave never asserts awready -> timeout=1 after 1024 cycles; clr_stats -> timeout=0
//  6 rst asserted in RESP with 4 entries queued -> outputs 0, busy=0, FIFO empty next cycle

Source files
------------

// File: rtl/synapse_weight_loader.sv
// synapse_weight_loader: buffers (index, weight) entries in a small FIFO and writes
// each one to the synaptic weight memory over AXI4-Lite, one transaction at a time.
// Out-of-range indices are dropped and counted as errors; completion of the entry
// flagged in_last is reported with a one-cycle done pulse.
module synapse_weight_loader #(
  parameter int unsigned NUM_SYNAPSES   = 72401,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_index,
  input  logic [15:0] in_weight,
  input  logic        in_last,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic        clr_stats,
  output logic        busy,
  output logic        done,
  output logic [31:0] wr_count,
  output logic [15:0] err_count,
  output logic        timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = 49;  // {last, weight[15:0], index[31:0]}
  localparam logic [31:0]   INDEX_LIMIT = 32'(NUM_SYNAPSES);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  state_t        state_reg;
  state_t        state_next;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // Full blocks input even if the head is popped this cycle, keeping in_ready registered-only.
  assign in_ready   = !fifo_full && !rst;
  assign push       = in_valid && in_ready;
  assign pop        = (state_reg == IDLE) && !fifo_empty;

  // Entry storage; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {in_last, in_weight, in_index};
    end
  end

  // FIFO pointers; reset flushes any queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Head-of-queue decode.
  logic [EW-1:0] head;
  logic [31:0]   head_index;
  logic [15:0]   head_weight;
  logic          head_last;
  logic          head_drop;
  logic [31:0]   head_addr;

  assign head        = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign head_index  = head[31:0];
  assign head_weight = head[47:32];
  assign head_last   = head[48];
  assign head_drop   = (head_index >= INDEX_LIMIT);
  assign head_addr   = BASE_ADDR + {head_index[29:0], 2'b00};

  // ---------------------------------------------------------------- FSM
  logic        aw_done_reg, aw_done_next;
  logic        w_done_reg,  w_done_next;
  logic [31:0] addr_reg;
  logic [15:0] data_reg;
  logic        last_reg;
  logic        done_reg,    done_next;
  logic        load_entry;
  logic        wr_inc;
  logic        err_inc;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;

  assign m_axi_awvalid = (state_reg == ADDR_DATA) && !aw_done_reg;
  assign m_axi_wvalid  = (state_reg == ADDR_DATA) && !w_done_reg;
  assign m_axi_bready  = (state_reg == RESP);
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_wdata   = {16'h0000, data_reg};
  assign m_axi_wstrb   = 4'b0011;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid  && m_axi_wready;
  assign b_hs  = m_axi_bready  && m_axi_bvalid;

  // Next-state and per-cycle event decode for the single-outstanding write engine.
  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    load_entry   = 1'b0;
    wr_inc       = 1'b0;
    err_inc      = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_drop) begin
            err_inc   = 1'b1;
            done_next = head_last;
          end else begin
            load_entry   = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = ADDR_DATA;
          end
        end
      end
      ADDR_DATA: begin
        if (aw_hs) aw_done_next = 1'b1;
        if (w_hs)  w_done_next  = 1'b1;
        if (aw_done_next && w_done_next) state_next = RESP;
      end
      RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp == 2'b00) wr_inc = 1'b1;
          else                      err_inc = 1'b1;
          done_next  = last_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, channel-complete flags and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      done_reg    <= done_next;
    end
  end

  // Capture the popped entry; held stable for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
      data_reg <= '0;
      last_reg <= 1'b0;
    end else if (load_entry) begin
      addr_reg <= head_addr;
      data_reg <= head_weight;
      last_reg <= head_last;
    end
  end

  // ---------------------------------------------------------------- statistics
  logic [31:0]   wr_count_reg;
  logic [15:0]   err_count_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic          timeout_reg;
  logic          tmo_quiet;

  // Counters: clear wins over a same-cycle increment; errors saturate.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      wr_count_reg  <= '0;
      err_count_reg <= '0;
    end else begin
      if (wr_inc) wr_count_reg <= wr_count_reg + 32'd1;
      if (err_inc && (err_count_reg != 16'hFFFF)) err_count_reg <= err_count_reg + 16'd1;
    end
  end

  // A cycle is "quiet" when a transaction is pending with no handshake and no state change.
  assign tmo_quiet = (state_reg != IDLE) && !aw_hs && !w_hs && !b_hs &&
                     (state_next == state_reg);

  // Stall watchdog: the counter saturates, the flag is sticky until clr_stats.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (!tmo_quiet)                tmo_cnt_reg <= '0;
      else if (tmo_cnt_reg != TMO_MAX) tmo_cnt_reg <= tmo_cnt_reg + TW'(1);

      if (clr_stats)                                   timeout_reg <= 1'b0;
      else if (tmo_quiet && (tmo_cnt_reg == TMO_LAST)) timeout_reg <= 1'b1;
    end
  end

  assign wr_count  = wr_count_reg;
  assign err_count = err_count_reg;
  assign timeout   = timeout_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != IDLE) || !fifo_empty;

endmodule
